// File: rtl/hazard_if.sv
// Hazard unit bundle: pipeline-side flags and specifiers in, stall/flush/forward controls out.
// When HAZARD_PERF_EN is defined the bundle also carries the two stall performance counters.
interface hazard_if #(
  parameter int REGW = 5
);
  logic [REGW-1:0] rsD;
  logic [REGW-1:0] rtD;
  logic [REGW-1:0] rsE;
  logic [REGW-1:0] rtE;
  logic [REGW-1:0] writeregE;
  logic [REGW-1:0] writeregM;
  logic [REGW-1:0] writeregW;
  logic            branchD;
  logic            memtoregE;
  logic            regwriteE;
  logic            memtoregM;
  logic            regwriteM;
  logic            regwriteW;
  logic            memreqM;
  logic            memreadyM;
  logic            stallF;
  logic            stallD;
  logic            stallE;
  logic            stallM;
  logic            flushE;
  logic            flushW;
  logic            forwardAD;
  logic            forwardBD;
  logic [1:0]      forwardAE;
  logic [1:0]      forwardBE;
  logic            mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0]     lwstall_cnt;
  logic [31:0]     memstall_cnt;
`endif

  // Pipeline side: supplies specifiers and flags, consumes the hazard controls.
  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output branchD, memtoregE, regwriteE, memtoregM, regwriteM, regwriteW,
    output memreqM, memreadyM,
    input  stallF, stallD, stallE, stallM, flushE, flushW,
    input  forwardAD, forwardBD, forwardAE, forwardBE, mem_err
`ifdef HAZARD_PERF_EN
    , input lwstall_cnt, memstall_cnt
`endif
  );

  // Hazard unit side.
  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  branchD, memtoregE, regwriteE, memtoregM, regwriteM, regwriteW,
    input  memreqM, memreadyM,
    output stallF, stallD, stallE, stallM, flushE, flushW,
    output forwardAD, forwardBD, forwardAE, forwardBE, mem_err
`ifdef HAZARD_PERF_EN
    , output lwstall_cnt, memstall_cnt
`endif
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard/stall engine for the 5-stage MIPS pipeline: forwarding selects, load-use and
// branch-compare stalls, and a data-memory wait FSM with timeout and sticky error flag.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall performance counters.
module hazard_unit #(
  parameter int REGW        = 5,
  parameter int TOW         = 8,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  hazard_if.slave hz
);

  localparam logic [0:0]     S_IDLE    = 1'b0;
  localparam logic [0:0]     S_WAIT    = 1'b1;
  localparam logic [TOW-1:0] TIMEOUT_C = TOW'(MEM_TIMEOUT);

  // Register 0 is hard-wired zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // Memory-stage result is newer than writeback, so it wins a double match.
  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src,
                                         input logic [REGW-1:0] wm, input logic rwm,
                                         input logic [REGW-1:0] ww, input logic rww);
    if (rwm && reg_match(src, wm))      return 2'b10;
    else if (rww && reg_match(src, ww)) return 2'b01;
    else                                return 2'b00;
  endfunction

  logic [0:0]     state_q, state_d;
  logic [TOW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           memstall;
  logic           lwstall;
  logic           brstall;

  // Forwarding selects and stall detection are purely combinational.
  always_comb begin
    hz.forwardAE = fwd_sel(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
    hz.forwardBE = fwd_sel(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
    hz.forwardAD = hz.regwriteM && reg_match(hz.rsD, hz.writeregM);
    hz.forwardBD = hz.regwriteM && reg_match(hz.rtD, hz.writeregM);
    lwstall = hz.memtoregE &&
              (reg_match(hz.rsD, hz.rtE) || reg_match(hz.rtD, hz.rtE));
    brstall = hz.branchD &&
              ((hz.regwriteE && (reg_match(hz.rsD, hz.writeregE) ||
                                 reg_match(hz.rtD, hz.writeregE))) ||
               (hz.memtoregM && (reg_match(hz.rsD, hz.writeregM) ||
                                 reg_match(hz.rtD, hz.writeregM))));
  end

  // Memory wait FSM next state; stall is asserted from the first not-ready cycle and
  // dropped in the cycle the access completes or is forced complete by timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    memstall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hz.memreqM && !hz.memreadyM) begin
          state_d  = S_WAIT;
          cnt_d    = TOW'(1);
          memstall = 1'b1;
        end
      end
      S_WAIT: begin
        if (!hz.memreqM || hz.memreadyM) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          memstall = 1'b1;
          cnt_d    = cnt_q + TOW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, timeout counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Stall/flush priority: memory wait freezes F..M and bubbles W; otherwise a
  // load-use or branch hazard holds F/D and bubbles E. All forced low during reset.
  always_comb begin
    hz.stallF = 1'b0;
    hz.stallD = 1'b0;
    hz.stallE = 1'b0;
    hz.stallM = 1'b0;
    hz.flushE = 1'b0;
    hz.flushW = 1'b0;
    if (!reset) begin
      if (memstall) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.stallM = 1'b1;
        hz.flushW = 1'b1;
      end else if (lwstall || brstall) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.flushE = 1'b1;
      end
    end
  end

  assign hz.mem_err = err_q;

`ifdef HAZARD_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] lwcnt_q, lwcnt_d;
  logic [31:0] mscnt_q, mscnt_d;

  // Counters advance once per hazard-stall cycle and stick at all-ones.
  always_comb begin
    lwcnt_d = lwcnt_q;
    mscnt_d = mscnt_q;
    if ((lwstall || brstall) && !memstall) lwcnt_d = sat_inc(lwcnt_q);
    if (memstall)                          mscnt_d = sat_inc(mscnt_q);
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lwcnt_q <= '0;
      mscnt_q <= '0;
    end else begin
      lwcnt_q <= lwcnt_d;
      mscnt_q <= mscnt_d;
    end
  end

  assign hz.lwstall_cnt  = lwcnt_q;
  assign hz.memstall_cnt = mscnt_q;
`endif

endmodule
